// File: rtl/rtc_bus_pkg.sv
// Shared definitions for the RTC bus writer: FSM states, register map and item indexing.
// Items 0..8 are the clock/timer registers in habilita bit order; 9 and 10 are the two commits.
package rtc_bus_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_SELECT,
      S_A_SETUP,
      S_A_STROBE,
      S_A_HOLD,
      S_D_SETUP,
      S_D_STROBE,
      S_D_HOLD,
      S_DONE
   } state_t;

   localparam logic [7:0] ADDR_ANO       = 8'h26;
   localparam logic [7:0] ADDR_MES       = 8'h25;
   localparam logic [7:0] ADDR_DIA       = 8'h24;
   localparam logic [7:0] ADDR_HORA      = 8'h23;
   localparam logic [7:0] ADDR_MIN       = 8'h22;
   localparam logic [7:0] ADDR_SEG       = 8'h21;
   localparam logic [7:0] ADDR_HT        = 8'h43;
   localparam logic [7:0] ADDR_MT        = 8'h42;
   localparam logic [7:0] ADDR_ST        = 8'h41;
   localparam logic [7:0] ADDR_CMD_TIME  = 8'hF1;
   localparam logic [7:0] ADDR_CMD_TIMER = 8'hF2;
   localparam logic [7:0] CMD_DATA       = 8'h00;

   localparam int HAB_ANO  = 0;
   localparam int HAB_MES  = 1;
   localparam int HAB_DIA  = 2;
   localparam int HAB_HORA = 3;
   localparam int HAB_MIN  = 4;
   localparam int HAB_SEG  = 5;
   localparam int HAB_HT   = 6;
   localparam int HAB_MT   = 7;
   localparam int HAB_ST   = 8;

   localparam int NUM_REGS       = 9;
   localparam int NUM_ITEMS      = 11;
   localparam int ITEM_CMD_TIME  = 9;
   localparam int ITEM_CMD_TIMER = 10;

   function automatic logic [7:0] item_addr(input logic [3:0] idx);
      case (idx)
         4'd0:    return ADDR_ANO;
         4'd1:    return ADDR_MES;
         4'd2:    return ADDR_DIA;
         4'd3:    return ADDR_HORA;
         4'd4:    return ADDR_MIN;
         4'd5:    return ADDR_SEG;
         4'd6:    return ADDR_HT;
         4'd7:    return ADDR_MT;
         4'd8:    return ADDR_ST;
         4'd9:    return ADDR_CMD_TIME;
         4'd10:   return ADDR_CMD_TIMER;
         default: return 8'h00;
      endcase
   endfunction

   // Lowest set bit wins, which yields registers first, then date/time, then timer commit.
   function automatic logic [3:0] lowest_pending(input logic [NUM_ITEMS-1:0] pend);
      logic [3:0] idx;
      idx = 4'd0;
      for (int i = NUM_ITEMS - 1; i >= 0; i--) begin
         if (pend[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Loadable down-counter timing one bus sub-phase; o_tc is high while the count sits at zero.
module rtc_bus_phase_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_tc
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/rtc_bus_writer.sv
// Write-side bus master for the RTC chip: snapshots values and mask on start, then walks
// each enabled register and commit through address and data phases on the muxed AD bus.
module rtc_bus_writer
   import rtc_bus_pkg::*;
#(
   parameter int PHASE_CYC = 4,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [8:0]        habilita,
   input  logic [7:0]        ano,
   input  logic [7:0]        mes,
   input  logic [7:0]        dia,
   input  logic [7:0]        hora,
   input  logic [7:0]        min,
   input  logic [7:0]        seg,
   input  logic [7:0]        ht,
   input  logic [7:0]        mt,
   input  logic [7:0]        st,
   output logic [ADDR_W-1:0] ad_out,
   output logic              ad_oe,
   output logic              cs_n,
   output logic              wr_n,
   output logic              rd_n,
   output logic              a_d,
   output logic              busy,
   output logic              listo_es,
   output logic [3:0]        dbg_state
);

   localparam logic [7:0] PHASE_LOAD = 8'(PHASE_CYC - 1);

   state_t                 r_state;
   state_t                 w_next;
   logic [NUM_ITEMS-1:0]   r_pend;
   logic [3:0]             r_sel;
   logic [7:0]             r_val [NUM_REGS];
   logic                   w_load;
   logic                   w_tc;
   logic [7:0]             w_addr;
   logic [7:0]             w_data;

   rtc_bus_phase_timer #(.W(8)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_load),
      .i_load_val (PHASE_LOAD),
      .o_tc       (w_tc)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_pend  <= '0;
         r_sel   <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_IDLE && start) begin
            r_pend <= {|habilita[HAB_ST:HAB_HT], |habilita[HAB_SEG:HAB_ANO], habilita};
         end else if (r_state == S_D_HOLD && w_tc) begin
            r_pend[r_sel] <= 1'b0;
         end
         if (r_state == S_SELECT) r_sel <= lowest_pending(r_pend);
      end
   end

   // Snapshot only; contents are meaningless until the first accepted start.
   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && start) begin
         r_val[HAB_ANO]  <= ano;
         r_val[HAB_MES]  <= mes;
         r_val[HAB_DIA]  <= dia;
         r_val[HAB_HORA] <= hora;
         r_val[HAB_MIN]  <= min;
         r_val[HAB_SEG]  <= seg;
         r_val[HAB_HT]   <= ht;
         r_val[HAB_MT]   <= mt;
         r_val[HAB_ST]   <= st;
      end
   end

   always_comb begin
      w_addr = item_addr(r_sel);
      case (r_sel)
         4'd0:    w_data = r_val[0];
         4'd1:    w_data = r_val[1];
         4'd2:    w_data = r_val[2];
         4'd3:    w_data = r_val[3];
         4'd4:    w_data = r_val[4];
         4'd5:    w_data = r_val[5];
         4'd6:    w_data = r_val[6];
         4'd7:    w_data = r_val[7];
         4'd8:    w_data = r_val[8];
         default: w_data = CMD_DATA;
      endcase
   end

   always_comb begin
      w_next   = r_state;
      w_load   = 1'b0;
      cs_n     = 1'b1;
      wr_n     = 1'b1;
      a_d      = 1'b0;
      ad_oe    = 1'b0;
      ad_out   = '0;
      busy     = 1'b1;
      listo_es = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) w_next = S_SELECT;
         end
         S_SELECT: begin
            if (r_pend == '0) begin
               w_next = S_DONE;
            end else begin
               w_next = S_A_SETUP;
               w_load = 1'b1;
            end
         end
         S_A_SETUP, S_A_STROBE, S_A_HOLD: begin
            cs_n   = 1'b0;
            ad_oe  = 1'b1;
            ad_out = ADDR_W'(w_addr);
            wr_n   = (r_state != S_A_STROBE);
            if (w_tc) begin
               w_load = 1'b1;
               w_next = (r_state == S_A_SETUP)  ? S_A_STROBE :
                        (r_state == S_A_STROBE) ? S_A_HOLD : S_D_SETUP;
            end
         end
         S_D_SETUP, S_D_STROBE, S_D_HOLD: begin
            cs_n   = 1'b0;
            ad_oe  = 1'b1;
            a_d    = 1'b1;
            ad_out = ADDR_W'(w_data);
            wr_n   = (r_state != S_D_STROBE);
            if (w_tc) begin
               w_load = (r_state != S_D_HOLD);
               w_next = (r_state == S_D_SETUP)  ? S_D_STROBE :
                        (r_state == S_D_STROBE) ? S_D_HOLD : S_SELECT;
            end
         end
         S_DONE: begin
            busy     = 1'b0;
            listo_es = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign rd_n      = 1'b1;
   assign dbg_state = 4'(r_state);

endmodule

// File: doc/rtc_bus_writer.md
Name: rtc_bus_writer

Overview:
- Write-side bus master for the external real-time-clock chip on the multiplexed address/data bus.
- Consumes the nine BCD values (year, month, day, hour, minute, second, timer h/m/s) and the 9-bit enable mask produced by the PicoBlaze controller.
- Issues one address-phase plus data-phase write per enabled register, then a transfer command for each touched group.
- Returns a one-cycle listo_es pulse to the controller when the whole sequence is finished.

Parameters:
- PHASE_CYC, 4: clock cycles per bus sub-phase (setup, strobe, hold); legal range 1..255.
- ADDR_W, 8: width of the AD bus and of the register addresses.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to run a write sequence
- habilita  in  9  enable mask; bit0 ano, 1 mes, 2 dia, 3 hora, 4 min, 5 seg, 6 ht, 7 mt, 8 st
- ano, mes, dia, hora, min, seg, ht, mt, st  in  8 each  BCD values to write
- ad_out  out  8  AD bus drive value
- ad_oe  out  1  AD bus output enable (tri-state control is outside this block)
- cs_n, wr_n, rd_n  out  1 each  chip select, write strobe, read strobe; all active-low
- a_d  out  1  0 = address phase, 1 = data phase
- busy  out  1  high from the cycle after an accepted start until listo_es
- listo_es  out  1  one-cycle done pulse

Behaviour:
- Reset (reset=0 at a clk edge):
  - Outputs: cs_n=1, wr_n=1, rd_n=1, a_d=0, ad_oe=0, ad_out=0, busy=0, listo_es=0.
  - FSM goes to IDLE and the pending mask clears.
  - Reset during a transfer abandons it: the bus is idle from the next cycle and no listo_es is produced.
- rd_n is held at 1 at all times.
- Start acceptance:
  - start is accepted only in IDLE.
  - On acceptance, all nine values and the mask are snapshotted into internal registers.
  - Later input changes do not affect the sequence in progress.
  - start while busy is ignored.
- Commit groups: if any of bits 0..5 are set, a date/time commit (addr 0xF1, data 0x00) is appended. If any of bits 6..8 are set, a timer commit (addr 0xF2, data 0x00) is appended.
- Ordering: registers are written in ascending bit order, then the date/time commit, then the timer commit.
- Register addresses: ano 0x26, mes 0x25, dia 0x24, hora 0x23, min 0x22, seg 0x21, ht 0x43, mt 0x42, st 0x41.
- FSM states: IDLE, SELECT, A_SETUP, A_STROBE, A_HOLD, D_SETUP, D_STROBE, D_HOLD, DONE.
- SELECT:
  - Takes 1 cycle and picks the lowest pending item (registers first, then commits).
  - If nothing is pending, go to DONE.
- Bus sub-phases: each of the six sub-phases lasts exactly PHASE_CYC cycles, timed by an 8-bit down-counter.
  - A_SETUP: cs_n=0, a_d=0, ad_oe=1, ad_out=addr, wr_n=1.
  - A_STROBE: as A_SETUP, with wr_n=0.
  - A_HOLD: wr_n=1, cs_n=0, addr held.
  - D_SETUP: a_d=1, ad_out=data, wr_n=1.
  - D_STROBE: as D_SETUP, with wr_n=0.
  - D_HOLD: wr_n=1, then clear the item's pending bit and return to SELECT.
  - cs_n=1 and ad_oe=0 in SELECT, IDLE and DONE, so there is a 1-cycle bus-idle gap between items.
- DONE: listo_es=1 and busy=0 for exactly 1 cycle, then IDLE.
- Latency: start edge to listo_es = N*(6*PHASE_CYC+1) + 2 cycles, where N = enabled registers + commits.
- habilita=0: SELECT goes straight to DONE and listo_es fires 2 cycles after start, with no bus activity.
- Data is passed through unmodified; BCD validity is the controller's responsibility.

Decomposition:
- Package rtc_bus_pkg holds:
  - the FSM state enum;
  - the nine register address constants and the two commit addresses/data (ADDR_CMD_TIME 0xF1, ADDR_CMD_TIMER 0xF2, CMD_DATA 0x00);
  - the habilita bit-index constants.
- One sub-module, rtc_bus_phase_timer: load/decrement counter with a terminal pulse, reused for all six sub-phases.

Test Plan:
- Reset with reset=0 for 10 cycles mid-sequence -> next cycle cs_n=1, wr_n=1, ad_oe=0, busy=0; no listo_es ever appears for the aborted run.
- habilita=9'h001, ano=8'h21, PHASE_CYC=4 -> two writes: (0x26,0x21) then (0xF1,0x00); wr_n low 4 cycles per phase; listo_es exactly 52 cycles after start.
- habilita=9'h1FF, all values 8'h12 -> 11 writes in order 0x26,0x25,0x24,0x23,0x22,0x21,0x43,0x42,0x41,0xF1,0xF2, each with data 0x12 (commits 0x00); one listo_es pulse.
- habilita=9'h1C0 -> only the timer writes plus the 0xF2 commit; no 0xF1 cycle appears.
- start re-pulsed while busy, and inputs changed to 8'h99 mid-sequence -> the second start is ignored and the bus still carries the snapshotted values.
- habilita=0 -> no cs_n activity; listo_es 2 cycles after start; a new start is accepted the following cycle.
